// File: rtl/cve2_clock_ctrl_if.sv
// Purpose : control/status bundle between the cve2 clock/sleep controller and its environment.
// Latency : n/a (signal bundle only).
// Backpress: none; all signals are levels sampled every cycle.
// Ports   : fetch_enable_i, core_busy_i, wake_i, wake_mask_i, force_en_i (into controller);
//           fetch_enable_o, clock_en_o, core_sleep_o, wake_cause_o, sleep_cycles_o (out of controller).
interface cve2_clock_ctrl_if #(
   parameter int unsigned NumWake       = 4,
   parameter int unsigned SleepCntWidth = 32
);
   logic                     fetch_enable_i;
   logic                     core_busy_i;
   logic [NumWake-1:0]       wake_i;
   logic [NumWake-1:0]       wake_mask_i;
   logic                     force_en_i;
   logic                     fetch_enable_o;
   logic                     clock_en_o;
   logic                     core_sleep_o;
   logic [NumWake-1:0]       wake_cause_o;
   logic [SleepCntWidth-1:0] sleep_cycles_o;

   // Environment side: drives requests, observes gating status.
   modport master (
      output fetch_enable_i, core_busy_i, wake_i, wake_mask_i, force_en_i,
      input  fetch_enable_o, clock_en_o, core_sleep_o, wake_cause_o, sleep_cycles_o
   );

   // Controller side.
   modport slave (
      input  fetch_enable_i, core_busy_i, wake_i, wake_mask_i, force_en_i,
      output fetch_enable_o, clock_en_o, core_sleep_o, wake_cause_o, sleep_cycles_o
   );
endinterface

// File: rtl/cve2_clock_ctrl.sv
// Purpose : core clock-gating and sleep controller (sticky fetch enable, idle hysteresis, maskable wake).
// Latency : gating after IdleHyst+1 idle cycles; wake raises clock_en_o combinationally in the same cycle.
// Backpress: none; level inputs, no handshake.
// Ports   : clk_i ungated clock, rst_i sync active-high reset, bus (slave modport of cve2_clock_ctrl_if).
module cve2_clock_ctrl #(
   parameter int unsigned NumWake       = 4,
   parameter int unsigned IdleHyst      = 8,
   parameter int unsigned SleepCntWidth = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   cve2_clock_ctrl_if.slave      bus
);

   localparam int unsigned CntW = (IdleHyst == 0) ? 1 : $clog2(IdleHyst + 1);
   localparam logic [CntW-1:0]          CntMax = CntW'(IdleHyst);
   localparam logic [CntW-1:0]          CntOne = CntW'(1);
   localparam logic [SleepCntWidth-1:0] SlpMax = '1;
   localparam logic [SleepCntWidth-1:0] SlpOne = SleepCntWidth'(1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_RUN,
      ST_DRAIN,
      ST_SLEEP
   } state_e;

   state_e                   r_state;
   state_e                   w_state_nxt;
   logic [CntW-1:0]          r_cnt;
   logic [CntW-1:0]          w_cnt_nxt;
   logic                     r_fen;
   logic                     r_busy;
   logic [NumWake-1:0]       r_cause;
   logic [NumWake-1:0]       w_cause_nxt;
   logic [SleepCntWidth-1:0] r_slp_cnt;

   logic [NumWake-1:0]       w_wake_vec;
   logic                     w_wake_any;
   logic                     w_idle;
   logic                     w_fsm_clk_en;
   logic                     w_slp_inc;
   logic                     w_clk_en;

   // Masking is applied combinationally so a mask change acts in the same cycle.
   assign w_wake_vec = bus.wake_i & bus.wake_mask_i;
   assign w_wake_any = |w_wake_vec;
   assign w_idle     = !r_busy && !w_wake_any;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_OFF;
         r_cnt     <= '0;
         r_fen     <= 1'b0;
         r_busy    <= 1'b0;
         r_cause   <= '0;
         r_slp_cnt <= '0;
      end else begin
         r_fen     <= r_fen | bus.fetch_enable_i;
         r_busy    <= bus.core_busy_i;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cause   <= w_cause_nxt;
         if (w_slp_inc && (r_slp_cnt != SlpMax)) begin
            r_slp_cnt <= r_slp_cnt + SlpOne;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_cause_nxt  = r_cause;
      w_fsm_clk_en = 1'b0;
      w_slp_inc    = 1'b0;
      case (r_state)
         ST_OFF: begin
            if (r_fen) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_fsm_clk_en = 1'b1;
            if (w_idle) begin
               if (IdleHyst == 0) begin
                  w_state_nxt = ST_SLEEP;
               end else begin
                  w_state_nxt = ST_DRAIN;
                  w_cnt_nxt   = CntOne;
               end
            end
         end
         ST_DRAIN: begin
            w_fsm_clk_en = 1'b1;
            // Any activity (including a wake arriving on the final count) restarts the hysteresis.
            if (!w_idle) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CntMax) begin
               w_state_nxt = ST_SLEEP;
            end else begin
               w_cnt_nxt = r_cnt + CntOne;
            end
         end
         ST_SLEEP: begin
            // Combinational so the wake edge reaches the core without a cycle of delay.
            w_fsm_clk_en = w_wake_any | r_busy;
            if (w_wake_any || r_busy) begin
               w_state_nxt = ST_RUN;
               w_cause_nxt = w_wake_vec;
            end else begin
               w_slp_inc = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
         end
      endcase
   end

   // The override only touches the output enable; FSM and counters are unaffected.
   assign w_clk_en = bus.force_en_i | w_fsm_clk_en;

   assign bus.fetch_enable_o = r_fen;
   assign bus.clock_en_o     = w_clk_en;
   assign bus.core_sleep_o   = r_fen & !w_clk_en;
   assign bus.wake_cause_o   = r_cause;
   assign bus.sleep_cycles_o = r_slp_cnt;

endmodule

// File: tb/tb_cve2_clock_ctrl.sv
module tb_cve2_clock_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic rst0;

   always #5 clk = ~clk;

   cve2_clock_ctrl_if #(.NumWake(4), .SleepCntWidth(4)) bus ();
   cve2_clock_ctrl #(.NumWake(4), .IdleHyst(8), .SleepCntWidth(4)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Second instance exercises the zero-hysteresis corner.
   cve2_clock_ctrl_if #(.NumWake(4), .SleepCntWidth(32)) bus0 ();
   cve2_clock_ctrl #(.NumWake(4), .IdleHyst(0), .SleepCntWidth(32)) u_dut0 (
      .clk_i (clk),
      .rst_i (rst0),
      .bus   (bus0.slave)
   );

   typedef struct {
      logic       rst;
      logic       fen;
      logic       busy;
      logic [3:0] wake;
      logic [3:0] mask;
      logic       frc;
      logic       e_fen;
      logic       e_clk;
      logic       e_slp;
      logic [3:0] e_cause;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int r, input int f, input int b, input int w, input int m, input int fo,
                      input int ef, input int ec, input int es, input int ecs, input int ecn);
      vec_t v;
      v.rst     = r[0];
      v.fen     = f[0];
      v.busy    = b[0];
      v.wake    = w[3:0];
      v.mask    = m[3:0];
      v.frc     = fo[0];
      v.e_fen   = ef[0];
      v.e_clk   = ec[0];
      v.e_slp   = es[0];
      v.e_cause = ecs[3:0];
      v.e_cnt   = ecn[3:0];
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      // Columns: rst fen busy wake mask force | fetch_en clock_en sleep cause sleep_cycles
      add(1,0,0,0,15,0, 0,0,0,0,0);
      add(1,0,0,0,15,1, 0,1,0,0,0);            // clock_en follows force during reset
      add(0,1,1,0,15,0, 0,0,0,0,0);            // one-cycle fetch enable pulse
      add(0,0,1,0,15,0, 1,0,1,0,0);            // latched, still OFF
      add(0,0,1,0,15,0, 1,1,0,0,0);            // RUN two edges after the pulse
      for (int i = 0; i < 10; i++) add(0,0,0,0,15,0, 1,1,0,0,0); // busy drop, RUN + 8 DRAIN
      for (int k = 0; k < 4; k++)  add(0,0,0,0,15,0, 1,0,1,0,k); // gated, counter runs
      add(0,0,0,4,15,0, 1,1,0,0,4);            // one-cycle wake: same-cycle clock
      for (int i = 0; i < 5; i++)  add(0,0,0,0,15,0, 1,1,0,4,4); // RUN then DRAIN
      add(0,0,1,0,15,0, 1,1,0,4,4);            // busy back during DRAIN
      for (int i = 0; i < 10; i++) add(0,0,0,0,15,0, 1,1,0,4,4); // abort, full restart
      add(0,0,0,4,11,0, 1,0,1,4,4);            // masked source cannot wake
      add(0,0,0,4,11,1, 1,1,0,4,5);            // force: clock on, FSM stays asleep
      add(0,0,0,4,11,0, 1,0,1,4,6);
      for (int i = 0; i < 11; i++) add(0,0,0,0,15,0, 1,0,1,4, (7 + i > 15) ? 15 : 7 + i);
      add(0,0,1,0,15,0, 1,0,1,4,15);           // busy input, registered next cycle
      add(0,0,0,0,15,0, 1,1,0,4,15);           // busy-only exit
      add(0,0,0,0,15,0, 1,1,0,0,15);           // cause cleared by busy exit
      for (int i = 0; i < 7; i++)  add(0,0,0,0,15,0, 1,1,0,0,15);
      add(0,0,0,1,15,0, 1,1,0,0,15);           // wake on final DRAIN count wins
      for (int i = 0; i < 9; i++)  add(0,0,0,0,15,0, 1,1,0,0,15);
      add(0,0,0,0,15,0, 1,0,1,0,15);
      add(1,0,0,0,15,0, 1,0,1,0,15);           // reset mid-SLEEP
      add(0,0,0,0,15,0, 0,0,0,0,0);
      add(0,0,0,0,15,0, 0,0,0,0,0);            // fetch enable not restored

      rst                 = 1'b1;
      bus.fetch_enable_i  = 1'b0;
      bus.core_busy_i     = 1'b0;
      bus.wake_i          = 4'h0;
      bus.wake_mask_i     = 4'hF;
      bus.force_en_i      = 1'b0;
      rst0                = 1'b1;
      bus0.fetch_enable_i = 1'b0;
      bus0.core_busy_i    = 1'b0;
      bus0.wake_i         = 4'h0;
      bus0.wake_mask_i    = 4'hF;
      bus0.force_en_i     = 1'b0;
      tick();
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         rst                = tbl[i].rst;
         bus.fetch_enable_i = tbl[i].fen;
         bus.core_busy_i    = tbl[i].busy;
         bus.wake_i         = tbl[i].wake;
         bus.wake_mask_i    = tbl[i].mask;
         bus.force_en_i     = tbl[i].frc;
         #2;
         chk($sformatf("row%0d fetch_enable_o", i), 32'(bus.fetch_enable_o), 32'(tbl[i].e_fen));
         chk($sformatf("row%0d clock_en_o", i),     32'(bus.clock_en_o),     32'(tbl[i].e_clk));
         chk($sformatf("row%0d core_sleep_o", i),   32'(bus.core_sleep_o),   32'(tbl[i].e_slp));
         chk($sformatf("row%0d wake_cause_o", i),   32'(bus.wake_cause_o),   32'(tbl[i].e_cause));
         chk($sformatf("row%0d sleep_cycles_o", i), 32'(bus.sleep_cycles_o), 32'(tbl[i].e_cnt));
         tick();
      end

      // Zero hysteresis: gate one cycle after the first idle RUN cycle.
      rst0 = 1'b0;
      bus0.fetch_enable_i = 1'b1;
      bus0.core_busy_i    = 1'b1;
      #2;
      chk("h0 clock_en off", 32'(bus0.clock_en_o), 32'd0);
      chk("h0 sleep off", 32'(bus0.core_sleep_o), 32'd0);
      tick();
      bus0.fetch_enable_i = 1'b0;
      #2;
      chk("h0 fetch_enable latched", 32'(bus0.fetch_enable_o), 32'd1);
      tick();
      bus0.core_busy_i = 1'b0;
      #2;
      chk("h0 run busy", 32'(bus0.clock_en_o), 32'd1);
      tick();
      #2;
      chk("h0 run idle", 32'(bus0.clock_en_o), 32'd1);
      tick();
      #2;
      chk("h0 gated", 32'(bus0.clock_en_o), 32'd0);
      chk("h0 sleep", 32'(bus0.core_sleep_o), 32'd1);
      chk("h0 sleep count start", bus0.sleep_cycles_o, 32'd0);
      tick();
      #2;
      chk("h0 sleep count one", bus0.sleep_cycles_o, 32'd1);
      bus0.wake_i      = 4'b0010;
      bus0.wake_mask_i = 4'b0010;
      #1;
      chk("h0 wake same cycle", 32'(bus0.clock_en_o), 32'd1);
      chk("h0 wake sleep low", 32'(bus0.core_sleep_o), 32'd0);
      tick();
      bus0.wake_i = 4'b0000;
      #2;
      chk("h0 wake cause", 32'(bus0.wake_cause_o), 32'h2);
      chk("h0 run after wake", 32'(bus0.clock_en_o), 32'd1);
      tick();
      #2;
      chk("h0 regated", 32'(bus0.clock_en_o), 32'd0);
      chk("h0 exit not counted", bus0.sleep_cycles_o, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
